// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register width, sequencer states, HALT opcode and
// the default multiply/divide EX occupancy used by hazard_control_unit.
package cpu_pkg;

  localparam int REG_W             = 4;
  localparam int MULDIV_CYCLES_DEF = 4;
  localparam logic [3:0] HALT_OPCODE = 4'hF;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    MULDIV = 2'd1,
    HALTED = 2'd2
  } state_t;

  // Pipeline control bundle driven by the sequencer each cycle
  typedef struct packed {
    logic pc_stop;
    logic if_id_hold;
    logic if_id_flush;
    logic id_ex_hold;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic muldiv_busy;
  } ctrl_t;

endpackage

// File: rtl/muldiv_busy_counter.sv
// Remaining-cycle counter for a multi-cycle multiply/divide occupying EX:
// parallel load, decrement to zero, zero flag.
module muldiv_busy_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] cnt,
  output logic       zero
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                   cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (dec && cnt != '0)   cnt <= cnt - 4'd1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer: load-use bubbles, taken-branch squash, mul/div EX
// occupancy and HALT. Optional stall counter under HAZARD_STALL_COUNT_EN.
module hazard_control_unit
  import cpu_pkg::*;
#(
  parameter int REG_W         = cpu_pkg::REG_W,
  parameter int MULDIV_CYCLES = cpu_pkg::MULDIV_CYCLES_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] id_op1,
  input  logic [REG_W-1:0] id_op2,
  input  logic             id_reads_op1,
  input  logic             id_reads_op2,
  input  logic             id_is_halt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_write_reg,
  input  logic             ex_start_muldiv,
  input  logic             ex_branch_taken,
  output logic             pc_stop,
  output logic             if_id_hold,
  output logic             if_id_flush,
  output logic             id_ex_hold,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             muldiv_busy,
`ifdef HAZARD_STALL_COUNT_EN
  output logic [15:0]      stall_cycles,
`endif
  output logic             halted
);

  state_t     state, state_nxt;
  ctrl_t      ctrl;
  logic       lu;
  logic       cnt_load, cnt_dec, cnt_zero;
  logic [3:0] cnt;

  // R0 is a genuinely written register, so it takes part in the compare
  assign lu = ex_mem_read &
              ((id_reads_op1 & (id_op1 == ex_write_reg)) |
               (id_reads_op2 & (id_op2 == ex_write_reg)));

  assign cnt_load = (state == RUN) & ex_start_muldiv;
  assign cnt_dec  = (state == MULDIV);

  muldiv_busy_counter u_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (4'(MULDIV_CYCLES - 2)),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (ex_start_muldiv)      state_nxt = MULDIV;
        else if (ex_branch_taken) state_nxt = RUN;
        else if (lu)              state_nxt = RUN;
        else if (id_is_halt)      state_nxt = HALTED;
      end
      MULDIV:  if (cnt_zero) state_nxt = RUN;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state)
      RUN: begin
        if (ex_start_muldiv) begin
          ctrl.pc_stop     = 1'b1;
          ctrl.if_id_hold  = 1'b1;
          ctrl.id_ex_hold  = 1'b1;
          ctrl.muldiv_busy = 1'b1;
        end else if (ex_branch_taken) begin
          // squashed ID instruction: its lu/halt no longer matter
          ctrl.if_id_flush = 1'b1;
          ctrl.id_ex_flush = 1'b1;
        end else if (lu) begin
          ctrl.pc_stop     = 1'b1;
          ctrl.if_id_hold  = 1'b1;
          ctrl.id_ex_flush = 1'b1;
        end else if (id_is_halt) begin
          ctrl.pc_stop     = 1'b1;
          ctrl.if_id_flush = 1'b1;
        end
      end
      MULDIV: begin
        ctrl.pc_stop      = 1'b1;
        ctrl.if_id_hold   = 1'b1;
        ctrl.id_ex_hold   = 1'b1;
        ctrl.muldiv_busy  = 1'b1;
        // final cycle lets the result fall into EX/MEM
        ctrl.ex_mem_flush = ~cnt_zero;
      end
      HALTED: begin
        ctrl.pc_stop     = 1'b1;
        ctrl.if_id_flush = 1'b1;
      end
      default: ctrl = '0;
    endcase
    if (reset) ctrl = '0;
  end

  assign pc_stop      = ctrl.pc_stop;
  assign if_id_hold   = ctrl.if_id_hold;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_hold   = ctrl.id_ex_hold;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_flush = ctrl.ex_mem_flush;
  assign muldiv_busy  = ctrl.muldiv_busy;
  assign halted       = (state == HALTED);

`ifdef HAZARD_STALL_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      stall_cycles <= '0;
    else if (ctrl.pc_stop && state != HALTED && stall_cycles != 16'hFFFF)
      stall_cycles <= stall_cycles + 16'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed plan steps followed by
// randomized traffic compared against a cycle-level behavioural model.
module tb_hazard_control_unit;

  localparam int MC = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] id_op1, id_op2, ex_write_reg;
  logic       id_reads_op1, id_reads_op2, id_is_halt;
  logic       ex_mem_read, ex_start_muldiv, ex_branch_taken;
  logic       pc_stop, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush;
  logic       ex_mem_flush, muldiv_busy, halted;
`ifdef HAZARD_STALL_COUNT_EN
  logic [15:0] stall_cycles;
`endif

  int vectors    = 0;
  int miscompares = 0;

  // model state: halted flag, remaining mul/div cycles, stall tally
  bit m_halted;
  int m_busy_left;
  int m_stall;

  hazard_control_unit #(.REG_W(4), .MULDIV_CYCLES(MC)) dut (
    .clock           (clock),
    .reset           (reset),
    .id_op1          (id_op1),
    .id_op2          (id_op2),
    .id_reads_op1    (id_reads_op1),
    .id_reads_op2    (id_reads_op2),
    .id_is_halt      (id_is_halt),
    .ex_mem_read     (ex_mem_read),
    .ex_write_reg    (ex_write_reg),
    .ex_start_muldiv (ex_start_muldiv),
    .ex_branch_taken (ex_branch_taken),
    .pc_stop         (pc_stop),
    .if_id_hold      (if_id_hold),
    .if_id_flush     (if_id_flush),
    .id_ex_hold      (id_ex_hold),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_flush    (ex_mem_flush),
    .muldiv_busy     (muldiv_busy),
`ifdef HAZARD_STALL_COUNT_EN
    .stall_cycles    (stall_cycles),
`endif
    .halted          (halted)
  );

  always #5 clock = ~clock;

  logic [7:0] obs;
  assign obs = {pc_stop, if_id_hold, if_id_flush, id_ex_hold,
                id_ex_flush, ex_mem_flush, muldiv_busy, halted};

  task automatic check8(input string tag, input logic [7:0] o, input logic [7:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] o, input logic [15:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic bit model_lu();
    return ex_mem_read && ((id_reads_op1 && id_op1 == ex_write_reg) ||
                           (id_reads_op2 && id_op2 == ex_write_reg));
  endfunction

  // order: pc_stop if_id_hold if_id_flush id_ex_hold id_ex_flush ex_mem_flush busy halted
  function automatic logic [7:0] model_out();
    logic [7:0] r = 8'b0;
    if (m_halted)                r = 8'b1010_0001;
    else if (m_busy_left > 0)    r = {4'b1101, 1'b0, (m_busy_left > 1), 2'b10};
    else if (ex_start_muldiv)    r = 8'b1101_0010;
    else if (ex_branch_taken)    r = 8'b0010_1000;
    else if (model_lu())         r = 8'b1100_1000;
    else if (id_is_halt)         r = 8'b1010_0000;
    return r;
  endfunction

  task automatic model_step();
    logic [7:0] o = model_out();
    if (o[7] && !m_halted && m_stall < 65535) m_stall++;
    if (m_halted) ;
    else if (m_busy_left > 0) m_busy_left--;
    else if (ex_start_muldiv) m_busy_left = MC - 1;
    else if (!ex_branch_taken && !model_lu() && id_is_halt) m_halted = 1;
  endtask

  task automatic model_reset();
    m_halted = 0; m_busy_left = 0; m_stall = 0;
  endtask

  task automatic idle();
    id_op1 = 0; id_op2 = 0; ex_write_reg = 4'hA;
    id_reads_op1 = 0; id_reads_op2 = 0; id_is_halt = 0;
    ex_mem_read = 0; ex_start_muldiv = 0; ex_branch_taken = 0;
  endtask

  task automatic randomize_inputs();
    id_op1          = 4'($urandom_range(0, 3));
    id_op2          = 4'($urandom_range(0, 3));
    ex_write_reg    = 4'($urandom_range(0, 3));
    id_reads_op1    = 1'($urandom_range(0, 1));
    id_reads_op2    = 1'($urandom_range(0, 1));
    ex_mem_read     = 1'($urandom_range(0, 1));
    ex_start_muldiv = ($urandom_range(0, 7) == 0);
    ex_branch_taken = ($urandom_range(0, 4) == 0);
    id_is_halt      = ($urandom_range(0, 19) == 0);
  endtask

  // inputs already applied at posedge+1; compare at negedge, then advance
  task automatic run_cycle(input string tag);
    #4;
    check8(tag, obs, model_out());
`ifdef HAZARD_STALL_COUNT_EN
    check16({tag, "_stall"}, stall_cycles, 16'(m_stall));
`endif
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic load_use_inputs();
    idle();
    ex_mem_read = 1; ex_write_reg = 4'h3; id_op1 = 4'h3; id_reads_op1 = 1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    model_reset();
    // outputs must be zero during reset even with a hazard presented
    load_use_inputs();
    ex_branch_taken = 1;
    #2 check8("reset_async", obs, 8'h00);
    @(posedge clock); #1;
    check8("reset_held", obs, 8'h00);
    reset = 1'b0;
    idle();
    run_cycle("run_idle");

    // load-use: exactly one bubble, then cleared once the load moves on
    load_use_inputs();
    run_cycle("lu_bubble");
    idle();
    run_cycle("lu_after");

    // branch beats load-use (and halt)
    load_use_inputs();
    ex_branch_taken = 1; id_is_halt = 1;
    run_cycle("br_over_lu");
    idle();
    run_cycle("br_after");

    // 4-cycle multiply/divide
    ex_start_muldiv = 1;
    run_cycle("md_c1");
    ex_start_muldiv = 1; ex_branch_taken = 1;
    run_cycle("md_c2");
    run_cycle("md_c3");
    load_use_inputs();
    run_cycle("md_c4");
    idle();
    run_cycle("md_c5_run");
`ifdef HAZARD_STALL_COUNT_EN
    check16("stall_lu_md", stall_cycles, 16'd5);
`endif

    // reset during second MULDIV cycle
    ex_start_muldiv = 1;
    run_cycle("md_rst_c1");
    idle();
    #1 reset = 1'b1;
    #1 check8("md_rst_async", obs, 8'h00);
    model_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    run_cycle("md_rst_run");
    ex_start_muldiv = 1;
    run_cycle("md2_c1");
    idle();
    for (int i = 0; i < 4; i++) run_cycle("md2_tail");

    // HALT sticks for 100 cycles regardless of inputs
    id_is_halt = 1;
    run_cycle("halt_enter");
    for (int i = 0; i < 100; i++) begin
      randomize_inputs();
      run_cycle("halt_hold");
    end
    check8("halt_final", obs & 8'b1000_0001, 8'b1000_0001);

    // randomized segments, each starting from reset
    for (int s = 0; s < 25; s++) begin
      reset = 1'b1;
      model_reset();
      #1 check8("rand_reset", obs, 8'h00);
      @(posedge clock); #1;
      reset = 1'b0;
      for (int i = 0; i < 40; i++) begin
        randomize_inputs();
        run_cycle("rand");
      end
    end

`ifdef HAZARD_STALL_COUNT_EN
    reset = 1'b1;
    model_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    load_use_inputs();
    for (int i = 0; i < 70000; i++) run_cycle("stall_sat");
    check16("stall_saturated", stall_cycles, 16'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Central pipeline sequencer for the 5-stage 16-bit CPU.
- Watches decode, execute and branch status each cycle and drives the stall, hold and flush controls:
  - PC stop
  - IF/ID hold and flush
  - ID/EX hold and flush
  - EX/MEM flush
- Handles four hazard classes: load-use hazards, taken branches, multi-cycle multiply/divide occupancy of EX, and HALT.
- Sits beside the forwarding unit in cpu; its outputs feed program_counter.pc_stop and each pipeline buffer's hold/flush pins.

Parameters:
- REG_W, 4, register-address width (op1/op2/write_reg fields).
- MULDIV_CYCLES, 4, total EX occupancy of a multiply/divide, in cycles. Legal range 2..15.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; forces state RUN immediately.
- id_op1  in  REG_W  source register 1 of the instruction in ID.
- id_op2  in  REG_W  source register 2 of the instruction in ID (already muxed to R0 when applicable).
- id_reads_op1  in  1  ID instruction actually reads op1.
- id_reads_op2  in  1  ID instruction actually reads op2.
- id_is_halt  in  1  ID holds the HALT opcode.
- ex_mem_read  in  1  EX instruction is a load.
- ex_write_reg  in  REG_W  destination register of the EX instruction.
- ex_start_muldiv  in  1  EX instruction is a multiply/divide, first EX cycle.
- ex_branch_taken  in  1  branch resolved taken in EX (also selects if_mux2 in2).
- pc_stop  out  1  freeze program counter.
- if_id_hold  out  1  hold IF/ID buffer.
- if_id_flush  out  1  clear IF/ID buffer to NOP.
- id_ex_hold  out  1  hold ID/EX buffer.
- id_ex_flush  out  1  clear ID/EX buffer to NOP.
- ex_mem_flush  out  1  insert bubble into EX/MEM.
- muldiv_busy  out  1  EX occupied by a multi-cycle op.
- halted  out  1  CPU halted (registered).

Behaviour:
- State register: RUN, MULDIV, HALTED. Reset value RUN. The busy counter cnt is 4 bits, reset value 0.
- All control outputs are combinational from state, cnt and inputs, except halted, which is decoded from state only.
- While reset is high, every output is 0.
- Load-use detect: lu = ex_mem_read & ((id_reads_op1 & id_op1 == ex_write_reg) | (id_reads_op2 & id_op2 == ex_write_reg)).
- RUN state, priority highest first:
  1. ex_start_muldiv:
     - Next state MULDIV, cnt <= MULDIV_CYCLES-2.
     - This cycle: pc_stop, if_id_hold, id_ex_hold, muldiv_busy = 1.
  2. ex_branch_taken:
     - if_id_flush = 1 and id_ex_flush = 1 for one cycle; PC loads the target.
     - Stays in RUN. Any lu or id_is_halt this cycle is ignored, because that instruction is squashed.
  3. lu:
     - pc_stop, if_id_hold, id_ex_flush = 1 for exactly one cycle (one bubble).
     - Stays in RUN; the next cycle re-evaluates with the load now in MEM.
  4. id_is_halt:
     - pc_stop = 1, if_id_flush = 1, next state HALTED.
     - HALT itself proceeds down the pipe.
- MULDIV state:
  - pc_stop, if_id_hold, id_ex_hold, ex_mem_flush, muldiv_busy = 1.
  - cnt decrements each cycle. When cnt == 0, the next state is RUN, and ex_mem_flush = 0 in that final cycle so the result enters EX/MEM.
  - ex_branch_taken and ex_start_muldiv are ignored while in MULDIV.
- HALTED state:
  - pc_stop = 1, if_id_flush = 1, halted = 1.
  - Leaves only through reset.
- Reset mid-operation: an asserted reset in MULDIV or HALTED returns to RUN with cnt = 0 immediately, without waiting for a clock edge.
- Register R0 is not excluded from the lu compare; R0 is a real written register in this ISA.

Optional Feature:
- Macro: HAZARD_STALL_COUNT_EN.
- When defined:
  - Adds output stall_cycles, 16 bits, reset value 0.
  - Increments on every clock edge where pc_stop = 1 and state != HALTED.
  - Saturates at 16'hFFFF.
- When undefined: the port and counter are absent, and the unit is otherwise identical.

Decomposition:
- Shared package cpu_pkg holds:
  - REG_W
  - the state encoding (RUN = 2'd0, MULDIV = 2'd1, HALTED = 2'd2)
  - the HALT opcode constant 4'hF
  - the MULDIV_CYCLES default
- One natural sub-module, muldiv_busy_counter: load, decrement, zero-flag.

Test Plan:
- Load-use: ex_mem_read = 1, ex_write_reg = 4'h3, id_op1 = 4'h3, id_reads_op1 = 1 -> pc_stop/if_id_hold/id_ex_flush = 1 for exactly 1 cycle, then 0 once the load moves on.
- Branch beats load-use: same stimulus plus ex_branch_taken = 1 -> if_id_flush = id_ex_flush = 1, pc_stop = 0, same cycle.
- Multiply/divide with MULDIV_CYCLES = 4: pulse ex_start_muldiv -> muldiv_busy high 4 cycles; ex_mem_flush high in cycles 2-3 only; back to RUN in cycle 5.
- HALT: id_is_halt = 1 -> halted = 1 from the next cycle and stays high for 100 cycles; pc_stop stays 1.
- Reset mid-MULDIV: assert reset during cycle 2 of MULDIV -> all outputs 0 asynchronously; after release, state RUN and cnt = 0.
- With HAZARD_STALL_COUNT_EN: one load-use plus one 4-cycle MULDIV -> stall_cycles = 5. Forcing 70000 stall cycles -> stall_cycles = 16'hFFFF.
